asymfifoctl_s1_df: RTL
======================

// Module: asymfifoctl_s1_df
// PURPOSE
//  Single-clock asymmetric FIFO RAM controller with dynamic (run-time) almost-empty/almost-full levels.
//  Drives an external dual-port RAM that is MAX_W wide with asynchronous (flow-through) read.
//  Packs narrow pushes into wide RAM words, or unpacks wide RAM words into narrow pops.
//  Adds a synchronous clear, an occupancy count and separate push/pop errors.
// PARAMETERS
//  DATA_IN_WIDTH   8   push data width; max/min width ratio K must be an integer >=1
//  DATA_OUT_WIDTH  32  pop data width
//  DEPTH           16  RAM words, 2..65536; need not be a power of two
//  ERR_MODE        0   0 = errors sticky until rst/clr; 1 = one-cycle error pulse per offending request
//  BYTE_ORDER      0   0 = first sub-word at MSB of the RAM word; 1 = first sub-word at LSB
//  (local) AW = clog2(DEPTH), MAX_W/MIN_W = max/min of the two widths, K = MAX_W/MIN_W
// PORTS
//  clk            in   1         single clock; all logic on rising edge
//  rst            in   1         asynchronous, active-high reset
//  clr            in   1         synchronous clear; same effect as rst
//  push_req_n     in   1         push request, active low
//  flush_n        in   1         active low; writes the partial word to RAM, zero-padded (in<out only)
//  pop_req_n      in   1         pop request, active low
//  data_in        in   DATA_IN_WIDTH   push data
//  ae_level       in   AW        almost-empty threshold, in RAM words
//  af_level       in   AW        almost-full threshold, in RAM words
//  rd_data        in   MAX_W     RAM read data at rd_addr, same cycle
//  we_n           out  1         RAM write enable, active low
//  wr_addr        out  AW        RAM write address
//  rd_addr        out  AW        RAM read address
//  wr_data        out  MAX_W     RAM write data
//  data_out       out  DATA_OUT_WIDTH  pop data (combinational from rd_data)
//  empty, almost_empty, half_full, almost_full  out 1 each   occupancy flags
//  ram_full       out  1         RAM holds DEPTH words
//  full           out  1         in<out: ram_full & wd_cntr==K-1; otherwise equals ram_full
//  part_wd        out  1         input buffer holds 1..K-1 sub-words (in<out only; otherwise 0)
//  push_error     out  1         overflow
//  pop_error      out  1         underflow
//  word_count     out  AW+1      RAM words occupied
// BEHAVIOUR
//  - Reset values (rst, or clr at the clock edge):
//    - pointers, word_count, wd_cntr, rd_cntr, input buffer and errors = 0
//    - we_n = 1, empty = 1, almost_empty = 1, all other flags = 0
//  - clr has priority over every request in the same cycle.
//  - Pointers wrap from DEPTH-1 to 0. Each pointer advances on the edge that ends the RAM write or RAM pop.
//  - RAM write (we_n = 0) is combinational in the cycle it occurs; wr_data and wr_addr are valid in that cycle.
//  - RAM write with word_count==DEPTH is never allowed.
//  - Push blocked on full: the push is rejected even if a pop occurs in the same cycle, and push_error is raised.
//  - Pop on empty is rejected and pop_error is raised, even if a push occurs in the same cycle.
//  - A same-cycle RAM write and RAM pop leave word_count unchanged.
//  - in==out: direct pass-through; one push = one RAM write, one pop = one RAM read.
//  - in<out, push without flush:
//    - wd_cntr 0..K-1 counts pushes into the input buffer.
//    - The push at wd_cntr==K-1 writes {buf,data_in} to RAM, ordered per BYTE_ORDER, and wd_cntr returns to 0.
//  - in<out, flush with part_wd & !ram_full:
//    - Writes the partial word, left-justified, with the empty sub-words zero.
//    - If push is also active, data_in becomes sub-word 0 of the next word (wd_cntr = 1); otherwise wd_cntr = 0.
//  - in<out, flush corner cases:
//    - Flush with part_wd & ram_full sets push_error and changes no state.
//    - Flush with !part_wd is ignored.
//  - in>out, pop side:
//    - rd_cntr 0..K-1 selects the data_out sub-word per BYTE_ORDER; each pop with !empty advances it.
//    - The pop at rd_cntr==K-1 advances rd_addr and word_count, and rd_cntr returns to 0.
//  - in>out, push: a push writes RAM directly.
//  - Flags are combinational from the registered word_count and the live thresholds:
//    - almost_empty = word_count <= ae_level
//    - almost_full = word_count >= DEPTH - af_level
//    - half_full = word_count >= (DEPTH+1)/2
//  - Changing a threshold takes effect the same cycle; there is no pointer side-effect.
//  - Errors: set on the edge after the offending request; behaviour per ERR_MODE.
// STRUCTURE
//  - Package asymfifo_pkg:
//    - clog2 function
//    - ERR_STICKY/ERR_PULSE and ORDER_MSB/ORDER_LSB constants
//    - width/ratio legality checks (elaboration $error when K is not an integer)
//  - Sub-module fifoctl_s1_core holds the symmetric single-clock engine:
//    - pointers, word_count, flags and error registers
//    - it is driven by the internal push_req_n_int/pop_req_n_int
//  - The top level holds the pack/unpack counters, the input buffer and the sub-word muxes, each in its own generate branch.
// TESTING
//  - 8->32, BYTE_ORDER 0, push 0x11,0x22,0x33,0x44:
//    - we_n=0 on the 4th push with wr_data=0x11223344 and wr_addr=0
//    - word_count becomes 1, empty=0
//  - 8->32, push 0xAA,0xBB then flush_n with push 0xCC:
//    - wr_data=0xAABB0000
//    - next cycle part_wd=1 with wd_cntr=1
//  - 32->8, DEPTH 4, BYTE_ORDER 1:
//    - write 0xDDCCBBAA; four pops give 0xAA,0xBB,0xCC,0xDD
//    - rd_addr advances only after the 4th pop
//  - DEPTH 5, fill to ram_full then push:
//    - push_error=1 (sticky in ERR_MODE 0), word_count stays 5
//    - a simultaneous pop+push when full leaves word_count=4
//  - Change af_level 1->3 with word_count=2: almost_full goes 0->1 in the same cycle.
//  - clr or async rst mid-pack (wd_cntr=2):
//    - everything returns to reset values; the next 4 pushes form a clean word at addr 0
//    - then pop on empty gives a one-cycle pop_error pulse in ERR_MODE 1

Source files
------------

// File: rtl/asymfifo_pkg.sv
// rtl/asymfifo_pkg.sv - shared constants and elaboration helpers for the asymmetric FIFO controller
package asymfifo_pkg;

    localparam int ERR_STICKY = 0;
    localparam int ERR_PULSE  = 1;
    localparam int ORDER_MSB  = 0;
    localparam int ORDER_LSB  = 1;

    // Ceiling log2; returns 0 for values of 1 or less.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // True when the wider of the two widths is an integer multiple of the narrower.
    function automatic bit ratio_ok(input int a, input int b);
        int mx;
        int mn;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return (mn > 0) && ((mx % mn) == 0);
    endfunction

endpackage

// File: rtl/fifoctl_s1_core.sv
// rtl/fifoctl_s1_core.sv - symmetric single-clock FIFO engine: pointers, occupancy, flags, errors
module fifoctl_s1_core
    import asymfifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ERR_MODE = 0,
    parameter int AW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push_req_n_int,
    input  logic          pop_req_n_int,
    input  logic          push_err_set,
    input  logic          pop_err_set,
    input  logic [AW-1:0] ae_level,
    input  logic [AW-1:0] af_level,
    output logic          we_n,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          empty,
    output logic          almost_empty,
    output logic          half_full,
    output logic          almost_full,
    output logic          ram_full,
    output logic          push_error,
    output logic          pop_error,
    output logic [AW:0]   word_count
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   HALF_W  = (AW+1)'((DEPTH + 1) / 2);
    localparam logic [AW-1:0] LAST_P  = AW'(DEPTH - 1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_word_count;
    logic          r_push_error;
    logic          r_pop_error;
    logic          w_wr;
    logic          w_rd;
    logic [AW:0]   w_af_ext;

    // A RAM write is never allowed into a full RAM, nor a pop from an empty one.
    assign w_wr     = !push_req_n_int && (r_word_count != DEPTH_W);
    assign w_rd     = !pop_req_n_int && (r_word_count != '0);
    assign w_af_ext = {1'b0, af_level};

    // Pointer, occupancy and error state; clr mirrors rst synchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_word_count <= '0;
            r_push_error <= 1'b0;
            r_pop_error  <= 1'b0;
        end else if (clr) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_word_count <= '0;
            r_push_error <= 1'b0;
            r_pop_error  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == LAST_P) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == LAST_P) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_word_count <= r_word_count + 1'b1;
                2'b01:   r_word_count <= r_word_count - 1'b1;
                default: r_word_count <= r_word_count;
            endcase
            if (ERR_MODE == ERR_STICKY) begin
                r_push_error <= r_push_error | push_err_set;
                r_pop_error  <= r_pop_error | pop_err_set;
            end else begin
                r_push_error <= push_err_set;
                r_pop_error  <= pop_err_set;
            end
        end
    end

    assign we_n         = !w_wr;
    assign wr_addr      = r_wr_ptr;
    assign rd_addr      = r_rd_ptr;
    assign word_count   = r_word_count;
    assign push_error   = r_push_error;
    assign pop_error    = r_pop_error;
    assign empty        = (r_word_count == '0);
    assign ram_full     = (r_word_count == DEPTH_W);
    assign almost_empty = (r_word_count <= {1'b0, ae_level});
    assign half_full    = (r_word_count >= HALF_W);
    // A threshold at or beyond DEPTH would underflow the subtraction; treat it as always almost full.
    assign almost_full  = (w_af_ext >= DEPTH_W) || (r_word_count >= (DEPTH_W - w_af_ext));

endmodule

// File: rtl/asymfifoctl_s1_df.sv
// rtl/asymfifoctl_s1_df.sv - asymmetric single-clock FIFO RAM controller with run-time thresholds
module asymfifoctl_s1_df
    import asymfifo_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int DEPTH          = 16,
    parameter int ERR_MODE       = 0,
    parameter int BYTE_ORDER     = 0,
    localparam int AW    = clog2(DEPTH),
    localparam int MAX_W = (DATA_IN_WIDTH > DATA_OUT_WIDTH) ? DATA_IN_WIDTH : DATA_OUT_WIDTH,
    localparam int MIN_W = (DATA_IN_WIDTH > DATA_OUT_WIDTH) ? DATA_OUT_WIDTH : DATA_IN_WIDTH,
    localparam int K     = MAX_W / MIN_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      push_req_n,
    input  logic                      flush_n,
    input  logic                      pop_req_n,
    input  logic [DATA_IN_WIDTH-1:0]  data_in,
    input  logic [AW-1:0]             ae_level,
    input  logic [AW-1:0]             af_level,
    input  logic [MAX_W-1:0]          rd_data,
    output logic                      we_n,
    output logic [AW-1:0]             wr_addr,
    output logic [AW-1:0]             rd_addr,
    output logic [MAX_W-1:0]          wr_data,
    output logic [DATA_OUT_WIDTH-1:0] data_out,
    output logic                      empty,
    output logic                      almost_empty,
    output logic                      half_full,
    output logic                      almost_full,
    output logic                      ram_full,
    output logic                      full,
    output logic                      part_wd,
    output logic                      push_error,
    output logic                      pop_error,
    output logic [AW:0]               word_count
);

    if (!ratio_ok(DATA_IN_WIDTH, DATA_OUT_WIDTH) || (DEPTH < 2) || (DEPTH > 65536) ||
        ((ERR_MODE != ERR_STICKY) && (ERR_MODE != ERR_PULSE)) ||
        ((BYTE_ORDER != ORDER_MSB) && (BYTE_ORDER != ORDER_LSB))) begin : g_bad_params
        $error("asymfifoctl_s1_df: illegal parameter combination");
    end

    logic w_push_req_n_int;
    logic w_pop_req_n_int;
    logic w_push_err;
    logic w_pop_err;
    logic w_ram_full;
    logic w_empty;

    fifoctl_s1_core #(
        .DEPTH    (DEPTH),
        .ERR_MODE (ERR_MODE),
        .AW       (AW)
    ) u_core (
        .clk            (clk),
        .rst            (rst),
        .clr            (clr),
        .push_req_n_int (w_push_req_n_int),
        .pop_req_n_int  (w_pop_req_n_int),
        .push_err_set   (w_push_err),
        .pop_err_set    (w_pop_err),
        .ae_level       (ae_level),
        .af_level       (af_level),
        .we_n           (we_n),
        .wr_addr        (wr_addr),
        .rd_addr        (rd_addr),
        .empty          (w_empty),
        .almost_empty   (almost_empty),
        .half_full      (half_full),
        .almost_full    (almost_full),
        .ram_full       (w_ram_full),
        .push_error     (push_error),
        .pop_error      (pop_error),
        .word_count     (word_count)
    );

    assign ram_full = w_ram_full;
    assign empty    = w_empty;

    if (DATA_IN_WIDTH == DATA_OUT_WIDTH) begin : g_equal
        logic w_unused_flush;
        assign w_unused_flush   = flush_n;
        assign w_push_req_n_int = push_req_n;
        assign w_pop_req_n_int  = pop_req_n;
        assign w_push_err       = !push_req_n && w_ram_full;
        assign w_pop_err        = !pop_req_n && w_empty;
        assign wr_data          = data_in;
        assign data_out         = rd_data;
        assign full             = w_ram_full;
        assign part_wd          = 1'b0;
    end else if (DATA_IN_WIDTH < DATA_OUT_WIDTH) begin : g_pack
        localparam int            CW     = (K > 1) ? clog2(K) : 1;
        localparam logic [CW-1:0] K_LAST = CW'(K - 1);
        localparam int            POS0   = (BYTE_ORDER == ORDER_LSB) ? 0 : K - 1;

        logic [CW-1:0]    r_wd_cntr;
        logic [MAX_W-1:0] r_buf;
        logic [CW-1:0]    w_pos;
        logic [MAX_W-1:0] w_sub;
        logic [MAX_W-1:0] w_sub0;
        logic [MAX_W-1:0] w_word;
        logic             w_push;
        logic             w_last;
        logic             w_full;
        logic             w_flush_act;

        // Sub-word slot for the current push, and the slot of the first sub-word of a word.
        assign w_pos       = (BYTE_ORDER == ORDER_LSB) ? r_wd_cntr : K_LAST - r_wd_cntr;
        assign w_sub       = MAX_W'(data_in) << (w_pos * MIN_W);
        assign w_sub0      = MAX_W'(data_in) << (POS0 * MIN_W);
        assign w_word      = r_buf | w_sub;
        assign w_push      = !push_req_n;
        assign w_last      = (r_wd_cntr == K_LAST);
        assign w_full      = w_ram_full && w_last;
        assign w_flush_act = !flush_n && (r_wd_cntr != '0);

        assign w_push_req_n_int = !(w_flush_act ? !w_ram_full : (w_push && w_last && !w_ram_full));
        assign w_push_err       = w_flush_act ? w_ram_full : (w_push && w_full);
        assign wr_data          = w_flush_act ? r_buf : w_word;
        assign w_pop_req_n_int  = pop_req_n;
        assign w_pop_err        = !pop_req_n && w_empty;
        assign data_out         = rd_data;
        assign full             = w_full;
        assign part_wd          = (r_wd_cntr != '0);

        // Input buffer packing; the buffer is cleared whenever its word goes to RAM so OR-merging stays valid.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wd_cntr <= '0;
                r_buf     <= '0;
            end else if (clr) begin
                r_wd_cntr <= '0;
                r_buf     <= '0;
            end else if (w_flush_act) begin
                if (!w_ram_full) begin
                    if (w_push) begin
                        r_buf     <= w_sub0;
                        r_wd_cntr <= CW'(1);
                    end else begin
                        r_buf     <= '0;
                        r_wd_cntr <= '0;
                    end
                end
            end else if (w_push && !w_full) begin
                if (w_last) begin
                    r_buf     <= '0;
                    r_wd_cntr <= '0;
                end else begin
                    r_buf     <= w_word;
                    r_wd_cntr <= r_wd_cntr + 1'b1;
                end
            end
        end
    end else begin : g_unpack
        localparam int            CW     = (K > 1) ? clog2(K) : 1;
        localparam logic [CW-1:0] K_LAST = CW'(K - 1);

        logic [CW-1:0] r_rd_cntr;
        logic [CW-1:0] w_pos;
        logic          w_pop_ok;
        logic          w_last;
        logic          w_unused_flush;

        assign w_unused_flush   = flush_n;
        assign w_pop_ok         = !pop_req_n && !w_empty;
        assign w_last           = (r_rd_cntr == K_LAST);
        assign w_pos            = (BYTE_ORDER == ORDER_LSB) ? r_rd_cntr : K_LAST - r_rd_cntr;
        assign data_out         = DATA_OUT_WIDTH'(rd_data >> (w_pos * MIN_W));
        assign w_pop_req_n_int  = !(w_pop_ok && w_last);
        assign w_pop_err        = !pop_req_n && w_empty;
        assign w_push_req_n_int = push_req_n;
        assign w_push_err       = !push_req_n && w_ram_full;
        assign wr_data          = data_in;
        assign full             = w_ram_full;
        assign part_wd          = 1'b0;

        // Sub-word read counter; the RAM word is released only on its last sub-word.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_cntr <= '0;
            end else if (clr) begin
                r_rd_cntr <= '0;
            end else if (w_pop_ok) begin
                r_rd_cntr <= w_last ? '0 : r_rd_cntr + 1'b1;
            end
        end
    end

endmodule
